// File: rtl/hfu_pkg.sv
// hfu_pkg: shared types and constants for the hazard/forwarding unit.
//   hfu_state_e : freeze FSM states (RUN, WAIT, ERR)
//   FWD_*       : fwd_sel encodings driven to the EX operand muxes
//   ZERO_REG    : register number hard-wired to zero, never forwarded or hazarded
package hfu_pkg;
   typedef enum logic [1:0] {RUN, WAIT, ERR} hfu_state_e;
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;
   localparam int ZERO_REG = 0;
endpackage

// File: rtl/hfu_fwd_lane.sv
// hfu_fwd_lane: forwarding select for a single EX source operand.
//   ex_rs_i                     : operand register number in EX
//   mem_rd_i / mem_regwrite_i   : producer in MEM
//   wb_rd_i / wb_regwrite_i     : producer in WB
//   fwd_sel_o                   : FWD_MEM, FWD_WB or FWD_RF (MEM wins over WB)
module hfu_fwd_lane
   import hfu_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] ex_rs_i,
   input  logic [AW-1:0] mem_rd_i,
   input  logic          mem_regwrite_i,
   input  logic [AW-1:0] wb_rd_i,
   input  logic          wb_regwrite_i,
   output logic [1:0]    fwd_sel_o
);
   logic mem_hit, wb_hit;
   assign mem_hit   = mem_regwrite_i && mem_rd_i != AW'(ZERO_REG) && mem_rd_i == ex_rs_i;
   assign wb_hit    = wb_regwrite_i && wb_rd_i != AW'(ZERO_REG) && wb_rd_i == ex_rs_i;
   assign fwd_sel_o = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX forwarding selects, load-use stall/flush and memory freeze FSM.
//   id_rs_i / id_rs_used_i          : ID sources (operand i at [i*AW +: AW]) and read flags
//   ex_rs_i                         : EX sources for forwarding
//   ex_rd_i / ex_regwrite_i / ex_memread_i : producer in EX
//   mem_rd_i / mem_regwrite_i / mem_load_i / mem_ready_i : producer in MEM
//   wb_rd_i / wb_regwrite_i         : producer in WB
//   fwd_sel_o                       : 2 bits per EX operand
//   stall_front_o / flush_idex_o    : load-use bubble
//   freeze_all_o                    : hold all pipeline registers while a load waits
//   timeout_err_o                   : sticky memory-timeout flag
//   HFU_STATS_EN adds saturating counters stat_lu_stalls_o, stat_freeze_cycles_o, stat_fwd_events_o.
// All outputs read 0 while rst is high.
module hazard_forward_unit
   import hfu_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int AW       = 5,
   parameter int MAX_WAIT = 16,
   parameter int CW       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_SRC*AW-1:0] id_rs_i,
   input  logic [NUM_SRC-1:0]    id_rs_used_i,
   input  logic [NUM_SRC*AW-1:0] ex_rs_i,
   input  logic [AW-1:0]         ex_rd_i,
   input  logic                  ex_regwrite_i,
   input  logic                  ex_memread_i,
   input  logic [AW-1:0]         mem_rd_i,
   input  logic                  mem_regwrite_i,
   input  logic                  mem_load_i,
   input  logic                  mem_ready_i,
   input  logic [AW-1:0]         wb_rd_i,
   input  logic                  wb_regwrite_i,
   output logic [NUM_SRC*2-1:0]  fwd_sel_o,
   output logic                  stall_front_o,
   output logic                  flush_idex_o,
   output logic                  freeze_all_o,
   output logic                  timeout_err_o
`ifdef HFU_STATS_EN
   ,
   output logic [CW-1:0]         stat_lu_stalls_o,
   output logic [CW-1:0]         stat_freeze_cycles_o,
   output logic [CW-1:0]         stat_fwd_events_o
`endif
);
   hfu_state_e    state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic [NUM_SRC*2-1:0] lane_sel;
   logic lu_hit, lu, pend, freeze;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
      hfu_fwd_lane #(.AW(AW)) u_lane (
         .ex_rs_i        (ex_rs_i[i*AW +: AW]),
         .mem_rd_i       (mem_rd_i),
         .mem_regwrite_i (mem_regwrite_i),
         .wb_rd_i        (wb_rd_i),
         .wb_regwrite_i  (wb_regwrite_i),
         .fwd_sel_o      (lane_sel[i*2 +: 2])
      );
   end

   always_comb begin
      lu_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         lu_hit = lu_hit | (id_rs_used_i[i] && id_rs_i[i*AW +: AW] == ex_rd_i);
   end

   assign lu     = ex_memread_i && ex_regwrite_i && ex_rd_i != AW'(ZERO_REG) && lu_hit;
   assign pend   = mem_load_i && !mem_ready_i;
   // Freeze rises combinationally on the first not-ready cycle (still in RUN) and
   // drops in the same cycle mem_ready arrives.
   assign freeze = (state_q == RUN && pend) || (state_q == WAIT && !mem_ready_i) || state_q == ERR;

   assign fwd_sel_o     = rst ? '0 : lane_sel;
   assign freeze_all_o  = !rst && freeze;
   assign stall_front_o = !rst && lu && !freeze;
   assign flush_idex_o  = stall_front_o;
   assign timeout_err_o = !rst && state_q == ERR;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: if (pend) begin
            state_d    = WAIT;
            wait_cnt_d = CW'(1);
         end
         WAIT: if (mem_ready_i) begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
            state_d    = ERR;
         end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
         end
         default: state_d = ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef HFU_STATS_EN
   logic [CW-1:0] lu_cnt_q, frz_cnt_q, fwd_cnt_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         lu_cnt_q  <= '0;
         frz_cnt_q <= '0;
         fwd_cnt_q <= '0;
      end else begin
         lu_cnt_q  <= lu_cnt_q + CW'(stall_front_o && lu_cnt_q != '1);
         frz_cnt_q <= frz_cnt_q + CW'(freeze_all_o && frz_cnt_q != '1);
         fwd_cnt_q <= fwd_cnt_q + CW'((|fwd_sel_o) && fwd_cnt_q != '1);
      end
   end
   assign stat_lu_stalls_o     = rst ? '0 : lu_cnt_q;
   assign stat_freeze_cycles_o = rst ? '0 : frz_cnt_q;
   assign stat_fwd_events_o    = rst ? '0 : fwd_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed-vector bench for hazard_forward_unit (NUM_SRC=2, MAX_WAIT=4).
module tb_hazard_forward_unit;
   localparam int NUM_SRC = 2, AW = 5, MAX_WAIT = 4, CW = 8;
   logic clk = 1'b0, rst = 1'b1;
   logic [NUM_SRC*AW-1:0] id_rs, ex_rs;
   logic [NUM_SRC-1:0]    id_rs_used;
   logic [AW-1:0]         ex_rd, mem_rd, wb_rd;
   logic ex_regwrite, ex_memread, mem_regwrite, mem_load, mem_ready, wb_regwrite;
   logic [NUM_SRC*2-1:0]  fwd_sel;
   logic stall_front, flush_idex, freeze_all, timeout_err;
`ifdef HFU_STATS_EN
   logic [CW-1:0] s_lu, s_frz, s_fwd;
`endif
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   hazard_forward_unit #(.NUM_SRC(NUM_SRC), .AW(AW), .MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs_i(id_rs), .id_rs_used_i(id_rs_used), .ex_rs_i(ex_rs),
      .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
      .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .mem_load_i(mem_load), .mem_ready_i(mem_ready),
      .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
      .fwd_sel_o(fwd_sel), .stall_front_o(stall_front), .flush_idex_o(flush_idex),
      .freeze_all_o(freeze_all), .timeout_err_o(timeout_err)
`ifdef HFU_STATS_EN
      , .stat_lu_stalls_o(s_lu), .stat_freeze_cycles_o(s_frz), .stat_fwd_events_o(s_fwd)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      id_rs = '0; ex_rs = '0; id_rs_used = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
      ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; mem_load = 0; mem_ready = 0; wb_regwrite = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic lu_hazard();
      ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd2}; id_rs_used = 2'b10;
   endtask

   initial begin
      clr();
      nxt();
      // in reset with every trigger active: outputs must read zero
      ex_rs = {5'd5, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1; mem_load = 1; lu_hazard();
      @(negedge clk);
      chk("rst_fwd", 32'(fwd_sel), 0);
      chk("rst_freeze", 32'(freeze_all), 0);
      chk("rst_stall", 32'(stall_front), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      nxt(); rst = 0; clr();
      // forwarding: MEM priority, WB fallback
      ex_rs = {5'd3, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1; wb_rd = 5'd5; wb_regwrite = 1;
      @(negedge clk); chk("fwd_mem_prio", 32'(fwd_sel), 32'b0001);
      nxt(); mem_regwrite = 0;
      @(negedge clk); chk("fwd_wb", 32'(fwd_sel), 32'b0010);
      nxt(); ex_rs = {5'd5, 5'd5};
      @(negedge clk); chk("fwd_wb_both", 32'(fwd_sel), 32'b1010);
      nxt(); clr(); mem_rd = 5'd0; mem_regwrite = 1; wb_rd = 5'd0; wb_regwrite = 1;
      @(negedge clk); chk("fwd_x0", 32'(fwd_sel), 0);
      chk("idle_stall", 32'(stall_front), 0);
      // load-use
      nxt(); clr(); lu_hazard();
      @(negedge clk); chk("lu_stall", 32'(stall_front), 1); chk("lu_flush", 32'(flush_idex), 1);
      nxt(); id_rs_used = 2'b00;
      @(negedge clk); chk("lu_unused", 32'(stall_front), 0);
      nxt(); clr();
      @(negedge clk); chk("lu_bubble_done", 32'(flush_idex), 0);
      nxt(); lu_hazard(); ex_rd = 5'd0; id_rs = {5'd0, 5'd0};
      @(negedge clk); chk("lu_x0", 32'(stall_front), 0);
      // 3-cycle freeze with a load-use hazard underneath
      nxt(); clr(); lu_hazard(); mem_load = 1;
      @(negedge clk); chk("frz1", 32'(freeze_all), 1); chk("frz1_noflush", 32'(flush_idex), 0);
      nxt();
      @(negedge clk); chk("frz2", 32'(freeze_all), 1); chk("frz2_nostall", 32'(stall_front), 0);
      nxt();
      @(negedge clk); chk("frz3", 32'(freeze_all), 1);
      nxt(); mem_ready = 1;
      @(negedge clk); chk("frz_drop", 32'(freeze_all), 0); chk("lu_after_frz", 32'(stall_front), 1);
      nxt(); clr();
      @(negedge clk); chk("back_run", 32'(freeze_all), 0); chk("no_timeout", 32'(timeout_err), 0);
      // timeout after MAX_WAIT freeze cycles
      nxt(); mem_load = 1;
      for (int k = 1; k <= MAX_WAIT; k++) begin
         @(negedge clk);
         chk($sformatf("to_frz%0d", k), 32'(freeze_all), 1);
         chk($sformatf("to_err_low%0d", k), 32'(timeout_err), 0);
         nxt();
      end
      @(negedge clk); chk("to_err", 32'(timeout_err), 1); chk("to_err_frz", 32'(freeze_all), 1);
      nxt(); mem_load = 0; mem_ready = 1;
      @(negedge clk); chk("to_sticky", 32'(timeout_err), 1);
`ifdef HFU_STATS_EN
      chk("st_lu", 32'(s_lu), 2);
      chk("st_frz", 32'(s_frz), 8);
      chk("st_fwd", 32'(s_fwd), 3);
`endif
      for (int k = 0; k < 260; k++) nxt();
      @(negedge clk); chk("to_sticky_long", 32'(timeout_err), 1);
`ifdef HFU_STATS_EN
      chk("st_frz_sat", 32'(s_frz), 255);
      chk("st_lu_hold", 32'(s_lu), 2);
`endif
      // reset out of ERR
      nxt(); rst = 1;
      @(negedge clk); chk("rst_err_out", 32'(timeout_err), 0); chk("rst_err_frz", 32'(freeze_all), 0);
      nxt(); rst = 0; clr();
      @(negedge clk); chk("err_cleared", 32'(timeout_err), 0); chk("err_run", 32'(freeze_all), 0);
`ifdef HFU_STATS_EN
      chk("st_clr_frz", 32'(s_frz), 0);
      chk("st_clr_fwd", 32'(s_fwd), 0);
`endif
      // reset mid-WAIT
      nxt(); mem_load = 1;
      nxt(); rst = 1;
      nxt(); rst = 0; clr();
      @(negedge clk); chk("rst_wait_run", 32'(freeze_all), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding controller for the 5-stage pipeline. It generalises the two-producer forwarding selector to `NUM_SRC` source operands per instruction and adds x0 exclusion. It also detects load-use hazards and runs a sequential freeze FSM for multi-cycle data-memory loads, with a sticky timeout error. It sits beside the ID/EX/MEM/WB pipeline registers and drives the forwarding muxes in EX and the PC, IF/ID and ID/EX enables and flushes.

## Interface
Parameters:
- `NUM_SRC`, 2: source operands per instruction (1..4).
- `AW`, 5: register-number width; register 0 is hard-wired zero.
- `MAX_WAIT`, 16: freeze cycles allowed before timeout (≥2).
- `CW`, 8: width of the wait counter and the stats counters.

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `id_rs`  in  NUM_SRC*AW  — sources of the instruction in ID; operand i occupies bits [i*AW +: AW].
- `id_rs_used`  in  NUM_SRC  — per-operand "actually read" flag.
- `ex_rs`  in  NUM_SRC*AW  — sources of the instruction in EX, used for forwarding.
- `ex_rd`, `ex_regwrite`, `ex_memread`  in  AW,1,1  — producer in EX.
- `mem_rd`, `mem_regwrite`, `mem_load`, `mem_ready`  in  AW,1,1,1  — producer in MEM; `mem_ready` marks load data valid.
- `wb_rd`, `wb_regwrite`  in  AW,1  — producer in WB.
- `fwd_sel`  out  NUM_SRC*2  — per EX operand: 00 = regfile, 01 = EX/MEM, 10 = MEM/WB.
- `stall_front`  out  1  — hold PC and IF/ID.
- `flush_idex`  out  1  — insert a bubble into ID/EX.
- `freeze_all`  out  1  — hold every pipeline register.
- `timeout_err`  out  1  — sticky memory-timeout flag.

## Operation
- **Forwarding (combinational, per operand i):**
  - 01 if `mem_regwrite`, `mem_rd`≠0 and `mem_rd`==`ex_rs[i]`.
  - Otherwise 10 if `wb_regwrite`, `wb_rd`≠0 and `wb_rd`==`ex_rs[i]`.
  - Otherwise 00.
  - MEM has priority over WB. Every bit of every operand is always assigned; no latches.
- **Load-use detection:** `lu` = `ex_memread` & `ex_regwrite` & `ex_rd`≠0 & OR over i of (`id_rs_used[i]` & `id_rs[i]`==`ex_rd`).
  - `stall_front` = `flush_idex` = `lu` & !`freeze_all`.
- **Freeze FSM**, states RUN, WAIT, ERR:
  - RUN:
    - If `mem_load` & !`mem_ready`: go to WAIT and set `wait_cnt`=1.
    - Otherwise stay in RUN.
  - WAIT:
    - If `mem_ready`: go to RUN and set `wait_cnt`=0.
    - Else if `wait_cnt`==MAX_WAIT-1: go to ERR.
    - Else increment `wait_cnt`.
  - ERR: absorbing until `rst`.
- **FSM outputs:**
  - `freeze_all` = (RUN & `mem_load` & !`mem_ready`) | (WAIT & !`mem_ready`) | ERR.
  - `timeout_err` = (state==ERR), decoded from a registered state.
- **Simultaneous events:** `freeze_all` overrides load-use, so no flush occurs while frozen. Load-use is re-evaluated in the cycle freeze drops.
- **Reset:** state=RUN, `wait_cnt`=0, stats=0. While `rst` is high, all outputs are forced to 0. `rst` asserted mid-WAIT or in ERR returns to RUN on the next edge.

## Timing
- `fwd_sel`, `stall_front` and `flush_idex` have zero-cycle (combinational) latency from their inputs.
- `freeze_all` rises in the same cycle a pending load is seen. It falls in the same cycle `mem_ready` is asserted.
- Timeout: the first freeze cycle is in RUN; after MAX_WAIT consecutive not-ready cycles, ERR is entered at the next edge. `timeout_err` is high one cycle after the MAX_WAIT-th freeze cycle.
- A classic load-use costs exactly one bubble cycle when memory is single-cycle.

## Configuration
- `HFU_STATS_EN` defined adds outputs `stat_lu_stalls`, `stat_freeze_cycles` and `stat_fwd_events` (CW each).
  - They are saturating counters incremented per cycle of `stall_front`, per cycle of `freeze_all`, and per cycle with any `fwd_sel`≠00.
  - All are cleared by `rst`.
- Undefined: no counters and no stats ports. All other behaviour is identical.

## Structure
- Shared package `hfu_pkg` holds:
  - the state enum (RUN, WAIT, ERR);
  - the `fwd_sel` encodings FWD_RF, FWD_MEM, FWD_WB;
  - the localparam for the zero register.
- One sub-module, `hfu_fwd_lane`: one operand's forwarding compare. It is instantiated NUM_SRC times in a generate loop.

## Test plan
- `ex_rs[0]`=5, `mem_rd`=5, `mem_regwrite`=1, `wb_rd`=5, `wb_regwrite`=1 → `fwd_sel[0]`=01 (MEM priority). With `mem_regwrite`=0 → 10.
- `mem_rd`=0, `mem_regwrite`=1, `ex_rs[1]`=0 → `fwd_sel[1]`=00 (x0 never forwarded).
- `ex_memread`=1, `ex_regwrite`=1, `ex_rd`=7, `id_rs[1]`=7, `id_rs_used`=2'b10 → `stall_front`=`flush_idex`=1 for one cycle. With `id_rs_used`=2'b00 → 0.
- `mem_load`=1, `mem_ready` low for 3 cycles then high → `freeze_all` high for exactly 3 cycles, FSM back in RUN, `timeout_err`=0. A load-use hazard present during the freeze does not flush.
- MAX_WAIT=4, `mem_ready` held low → `timeout_err` rises after the 4th freeze cycle and stays high. Asserting `rst` for one cycle clears it and returns the FSM to RUN.
- With `HFU_STATS_EN` defined: after the scenarios above, counters match the counted cycles, and `stat_freeze_cycles` saturates at 2^CW-1 under a long freeze.
